fetch_seq: RTL and testbench

//   Instruction-fetch sequencer that owns the architectural PC and drives the instruction memory.
//   - Issues sequential PC+4 fetch requests.
//   - Accepts redirects (branch/jal/jalr targets) resolved in execute.
//   - Drops stale in-flight responses after a redirect.
//   - Buffers fetched instructions for decode.

---
 rtl/fetch_pkg.sv | 14 +
 rtl/fetch_buf.sv | 55 +++++
 rtl/fetch_seq.sv | 139 +++++++++++++
 tb/tb_fetch_seq.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch sequencer.
package fetch_pkg;

  typedef enum logic [1:0] {
    BOOT,
    RUN,
    FLUSH,
    TRAP
  } fetch_state_e;

  localparam int unsigned INSTR_W = 32;
  localparam int unsigned PC_INC  = 4;

endpackage

// File: rtl/fetch_buf.sv
// Synchronous FIFO used both for the in-flight address queue and the decode buffer.
// Clear has priority over push and pop; pop on empty is ignored.
module fetch_buf #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned W     = 96,
  parameter int unsigned CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear_i,
  input  logic          push_i,
  input  logic [W-1:0]  data_i,
  input  logic          pop_i,
  output logic [W-1:0]  head_o,
  output logic [CW-1:0] count_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] rd_q, wr_q;
  logic [CW-1:0] cnt_q;
  logic          do_pop;

  always_comb begin
    do_pop  = pop_i && (cnt_q != '0);
    head_o  = mem_q[rd_q];
    count_o = cnt_q;
  end

  always_ff @(posedge clk) begin
    if (rst || clear_i) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push_i) wr_q <= wr_q + 1'b1;
      if (do_pop) rd_q <= rd_q + 1'b1;
      cnt_q <= cnt_q + CW'(push_i) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && !clear_i && push_i) mem_q[wr_q] <= data_i;
  end

  // The credit check upstream must make overflow impossible.
  always_ff @(posedge clk) begin
    if (!rst && !clear_i) begin
      assert (!push_i || do_pop || (cnt_q != CW'(DEPTH)))
        else $error("fetch_buf overflow");
    end
  end

endmodule

// File: rtl/fetch_seq.sv
// Instruction-fetch sequencer: owns the PC, issues imem requests under a credit limit,
// kills stale responses after a redirect and buffers fetched words for decode.
// Optional FETCH_MISALIGN_TRAP_EN: misaligned redirect targets produce a trap entry.
module fetch_seq
  import fetch_pkg::*;
#(
  parameter int unsigned     XLEN      = 64,
  parameter logic [XLEN-1:0] RESET_PC  = XLEN'(64'h0000_0000_8000_0000),
  parameter int unsigned     MAX_OUTST = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               redir_valid,
  input  logic [XLEN-1:0]    redir_pc,
  output logic               imem_req_valid,
  input  logic               imem_req_ready,
  output logic [XLEN-1:0]    imem_req_addr,
  input  logic               imem_rsp_valid,
  input  logic [INSTR_W-1:0] imem_rsp_data,
  output logic               if_valid,
  input  logic               if_ready,
  output logic [XLEN-1:0]    if_pc,
  output logic [INSTR_W-1:0] if_instr,
  output logic               if_misalign
);

  localparam int unsigned CW = $clog2(MAX_OUTST + 1);
`ifdef FETCH_MISALIGN_TRAP_EN
  localparam int unsigned BW = XLEN + INSTR_W + 1;
`else
  localparam int unsigned BW = XLEN + INSTR_W;
`endif

  fetch_state_e    state_q;
  logic [XLEN-1:0] fetch_pc_q;
  logic [CW-1:0]   kill_q, kill_d;
  logic [CW-1:0]   outst, outst_d, buf_count;
  logic [XLEN-1:0] rsp_pc, redir_tgt;
  logic [BW-1:0]   buf_wdata, buf_head;
  logic            redir, req_hs, buf_push, buf_pop;
`ifdef FETCH_MISALIGN_TRAP_EN
  logic            trap_pend_q;
  logic            misalign;
`endif

  always_comb begin
    redir          = redir_valid && (state_q != BOOT);
    imem_req_valid = (state_q == RUN) &&
                     ((int'(outst) + int'(buf_count)) < int'(MAX_OUTST));
    imem_req_addr  = fetch_pc_q;
    req_hs         = imem_req_valid && imem_req_ready;
    outst_d        = outst + CW'(req_hs) - CW'(imem_rsp_valid);
    kill_d         = kill_q - CW'(imem_rsp_valid && (kill_q != '0));
    buf_pop        = if_valid && if_ready;
    buf_push       = !redir && (state_q == RUN) && imem_rsp_valid && (kill_q == '0);
`ifdef FETCH_MISALIGN_TRAP_EN
    misalign       = (redir_pc[1:0] != 2'b00);
    redir_tgt      = redir_pc;
    buf_wdata      = {1'b0, rsp_pc, imem_rsp_data};
    // The trap entry is presented once, only after every stale response is gone.
    if (!redir && (state_q == TRAP) && (kill_q == '0) && trap_pend_q) begin
      buf_push  = 1'b1;
      buf_wdata = {1'b1, fetch_pc_q, {INSTR_W{1'b0}}};
    end
`else
    redir_tgt      = redir_pc & ~XLEN'(3);
    buf_wdata      = {rsp_pc, imem_rsp_data};
`endif
  end

  assign if_valid = (buf_count != '0);
  assign if_pc    = if_valid ? buf_head[INSTR_W +: XLEN] : '0;
  assign if_instr = if_valid ? buf_head[INSTR_W-1:0]     : '0;
`ifdef FETCH_MISALIGN_TRAP_EN
  assign if_misalign = if_valid && buf_head[BW-1];
`else
  assign if_misalign = 1'b0;
`endif

  // Address queue: its occupancy is the in-flight request count.
  fetch_buf #(.DEPTH(MAX_OUTST), .W(XLEN), .CW(CW)) u_addr_q (
    .clk     (clk),
    .rst     (rst),
    .clear_i (1'b0),
    .push_i  (req_hs),
    .data_i  (fetch_pc_q),
    .pop_i   (imem_rsp_valid),
    .head_o  (rsp_pc),
    .count_o (outst)
  );

  fetch_buf #(.DEPTH(MAX_OUTST), .W(BW), .CW(CW)) u_ibuf (
    .clk     (clk),
    .rst     (rst),
    .clear_i (redir),
    .push_i  (buf_push),
    .data_i  (buf_wdata),
    .pop_i   (buf_pop),
    .head_o  (buf_head),
    .count_o (buf_count)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= BOOT;
      fetch_pc_q <= RESET_PC;
      kill_q     <= '0;
`ifdef FETCH_MISALIGN_TRAP_EN
      trap_pend_q <= 1'b0;
`endif
    end else if (redir) begin
      fetch_pc_q <= redir_tgt;
      kill_q     <= outst_d;
      if (outst_d == '0) state_q <= RUN;
      else               state_q <= FLUSH;
`ifdef FETCH_MISALIGN_TRAP_EN
      trap_pend_q <= misalign;
      if (misalign) state_q <= TRAP;
`endif
    end else begin
      case (state_q)
        BOOT:  state_q <= RUN;
        RUN:   if (req_hs) fetch_pc_q <= fetch_pc_q + XLEN'(PC_INC);
        FLUSH: begin
          kill_q <= kill_d;
          if (kill_d == '0) state_q <= RUN;
        end
        TRAP: begin
          kill_q <= kill_d;
`ifdef FETCH_MISALIGN_TRAP_EN
          if (kill_q == '0) trap_pend_q <= 1'b0;
`endif
        end
        default: state_q <= BOOT;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_seq.sv
// Bench for fetch_seq: in-order imem model with random latency/back-pressure and a
// stream model (expected request and decode PCs restart at each redirect target).
module tb_fetch_seq;
  localparam int unsigned XLEN      = 64;
  localparam logic [63:0] RESET_PC  = 64'h0000_0000_8000_0000;
  localparam int unsigned MAX_OUTST = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        redir_valid;
  logic [63:0] redir_pc;
  logic        imem_req_valid, imem_req_ready;
  logic [63:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        if_valid, if_ready;
  logic [63:0] if_pc;
  logic [31:0] if_instr;
  logic        if_misalign;

  fetch_seq #(.XLEN(XLEN), .RESET_PC(RESET_PC), .MAX_OUTST(MAX_OUTST)) dut (
    .clk            (clk),
    .rst            (rst),
    .redir_valid    (redir_valid),
    .redir_pc       (redir_pc),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .if_valid       (if_valid),
    .if_ready       (if_ready),
    .if_pc          (if_pc),
    .if_instr       (if_instr),
    .if_misalign    (if_misalign)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [63:0] pend[$];
  logic [63:0] exp_req, exp_pc, trap_pc, first_pc, first_req, redir_tgt;
  int unsigned p_ready, p_rsp, p_dec, p_redir;
  int          pops, reqs;
  bit          trap_mode, trap_seen, arm4, hit4, saw_zero, redir_now;
  bit          cap_pc, cap_req;

  function automatic logic [31:0] word(input logic [63:0] a);
    return a[31:0] ^ a[63:32] ^ 32'h1357_9BDF;
  endfunction

  function automatic bit roll(input int unsigned pct);
    return $urandom_range(99) < pct;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock: sample outputs at negedge, choose inputs, check, advance the model.
  task automatic cycle();
    logic        rv, iv, im, hs_rdy, rsp, dec, rd;
    logic [63:0] ra, ip, tgt;
    logic [31:0] ii;
    @(negedge clk);
    rv = imem_req_valid; ra = imem_req_addr;
    iv = if_valid; ip = if_pc; ii = if_instr; im = if_misalign;
    hs_rdy = roll(p_ready);
    rsp    = (pend.size() != 0) && roll(p_rsp);
    dec    = roll(p_dec);
    rd     = redir_now || roll(p_redir);
    tgt    = redir_now ? redir_tgt : 64'h8000_0000 + 64'($urandom_range(1023)) * 64'd4;
    if (arm4 && rv && pend.size() != 0) begin
      rd = 1'b1; hs_rdy = 1'b1; rsp = 1'b1; tgt = 64'h8000_2000;
      arm4 = 1'b0; hit4 = 1'b1;
    end
    redir_now      = 1'b0;
    imem_req_ready = hs_rdy;
    imem_rsp_valid = rsp;
    imem_rsp_data  = rsp ? word(pend[0]) : 32'h0;
    if_ready       = dec;
    redir_valid    = rd;
    redir_pc       = tgt;

    if (trap_mode) chk("trap_noreq", 64'(rv), 64'd0);
    else if (rv) chk("req_addr", ra, exp_req);
    if (iv && dec) begin
      if (cap_pc) begin first_pc = ip; cap_pc = 1'b0; end
      if (trap_mode) begin
        chk("trap_once", 64'(trap_seen), 64'd0);
        chk("trap_pc", ip, trap_pc);
        chk("trap_instr", 64'(ii), 64'd0);
        chk("trap_mis", 64'(im), 64'd1);
        trap_seen = 1'b1;
      end else begin
        chk("if_pc", ip, exp_pc);
        chk("if_instr", 64'(ii), 64'(word(exp_pc)));
        chk("if_mis", 64'(im), 64'd0);
        exp_pc += 64'd4;
      end
      pops++;
    end

    if (rsp) void'(pend.pop_front());
    if (rv && hs_rdy) begin
      if (cap_req) begin first_req = ra; cap_req = 1'b0; end
      if (ra == 64'd0) saw_zero = 1'b1;
      pend.push_back(ra);
      exp_req += 64'd4;
      reqs++;
    end
    chk("inflight", 64'(pend.size() <= MAX_OUTST), 64'd1);
    if (rd) begin
      cap_pc = 1'b1; cap_req = 1'b1;
`ifdef FETCH_MISALIGN_TRAP_EN
      trap_mode = (tgt[1:0] != 2'b00);
      trap_seen = 1'b0;
      trap_pc   = tgt;
      exp_req   = tgt;
      exp_pc    = tgt;
`else
      exp_req = tgt & ~64'h3;
      exp_pc  = tgt & ~64'h3;
`endif
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = 32'h0;
    redir_valid = 1'b0; redir_pc = 64'h0; if_ready = 1'b0;
    @(negedge clk);
    chk("rst_req_valid", 64'(imem_req_valid), 64'd0);
    chk("rst_req_addr", imem_req_addr, RESET_PC);
    chk("rst_if_valid", 64'(if_valid), 64'd0);
    chk("rst_if_pc", if_pc, 64'd0);
    chk("rst_if_instr", 64'(if_instr), 64'd0);
    chk("rst_if_mis", 64'(if_misalign), 64'd0);
    pend.delete();
    exp_req = RESET_PC; exp_pc = RESET_PC;
    trap_mode = 1'b0; trap_seen = 1'b0; redir_now = 1'b0; arm4 = 1'b0;
    cap_pc = 1'b0; cap_req = 1'b0;
    rst = 1'b0;
  endtask

  initial begin
    int p0;
    p_redir = 0;
    do_reset();

    // Streaming with immediate responses and an always-ready decoder.
    p_ready = 100; p_rsp = 100; p_dec = 100;
    cap_req = 1'b1;
    repeat (30) cycle();
    chk("t1_first_req", first_req, RESET_PC);
    chk("t1_progress", 64'(pops >= 10), 64'd1);

    // Decode stall: credits exhaust with both words buffered.
    p_dec = 0;
    repeat (10) cycle();
    chk("t2_req_stop", 64'(imem_req_valid), 64'd0);
    chk("t2_if_valid", 64'(if_valid), 64'd1);
    chk("t2_no_inflight", 64'(pend.size()), 64'd0);
    p_dec = 100; p0 = pops;
    repeat (20) cycle();
    chk("t2_resume", 64'(pops - p0 >= 5), 64'd1);

    // Redirect with two requests in flight.
    p_rsp = 0;
    for (int i = 0; i < 20 && pend.size() != MAX_OUTST; i++) cycle();
    chk("t3_two_outst", 64'(pend.size()), 64'd2);
    redir_now = 1'b1; redir_tgt = 64'h8000_1000;
    cycle();
    p_rsp = 100;
    repeat (20) cycle();
    chk("t3_first_pc", first_pc, 64'h8000_1000);

    // Redirect coinciding with a request handshake and a response.
    hit4 = 1'b0; arm4 = 1'b1;
    for (int i = 0; i < 30 && !hit4; i++) cycle();
    chk("t4_hit", 64'(hit4), 64'd1);
    arm4 = 1'b0;
    repeat (20) cycle();
    chk("t4_first_pc", first_pc, 64'h8000_2000);

    // Misaligned redirect target.
    redir_now = 1'b1; redir_tgt = 64'h8000_1002;
    cycle();
    repeat (15) cycle();
`ifdef FETCH_MISALIGN_TRAP_EN
    chk("t5_trap_seen", 64'(trap_seen), 64'd1);
    chk("t5_trap_pc", first_pc, 64'h8000_1002);
    chk("t5_quiet", 64'(if_valid), 64'd0);
    redir_now = 1'b1; redir_tgt = 64'h8000_3000;
    cycle();
    repeat (15) cycle();
    chk("t5_leave_pc", first_pc, 64'h8000_3000);
`else
    chk("t5_first_req", first_req, 64'h8000_1000);
    chk("t5_first_pc", first_pc, 64'h8000_1000);
`endif

    // Address wrap at the top of the address space.
    saw_zero = 1'b0;
    redir_now = 1'b1; redir_tgt = 64'hFFFF_FFFF_FFFF_FFFC;
    cycle();
    repeat (15) cycle();
    chk("t6_wrap", 64'(saw_zero), 64'd1);

    // Reset while killing stale responses.
    p_rsp = 0;
    for (int i = 0; i < 20 && pend.size() == 0; i++) cycle();
    chk("t6_pending", 64'(pend.size() != 0), 64'd1);
    redir_now = 1'b1; redir_tgt = 64'h8000_4000;
    cycle();
    do_reset();
    p_ready = 100; p_rsp = 100; p_dec = 100; cap_req = 1'b1;
    repeat (10) cycle();
    chk("t6_restart_req", first_req, RESET_PC);

    // Randomised traffic with occasional redirects.
    for (int seg = 0; seg < 12; seg++) begin
      p_ready = $urandom_range(30, 100);
      p_rsp   = $urandom_range(30, 100);
      p_dec   = $urandom_range(20, 100);
      p_redir = 3;
      repeat (50) cycle();
    end
    p_ready = 100; p_rsp = 100; p_dec = 100; p_redir = 0;
    p0 = pops;
    repeat (30) cycle();
    chk("final_progress", 64'(pops - p0 >= 10), 64'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
